entity_renderer: RTL and testbench

ENTITY_RENDERER -- requirements
Module: entity_renderer

---
 rtl/entity_renderer_if.sv | 34 +++
 rtl/entity_renderer.sv | 179 +++++++++++++++++
 tb/tb_entity_renderer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/entity_renderer_if.sv
// Request/pixel bus between an entity source and the entity renderer.
// Optional erase input is present only when ENTITY_RENDERER_ERASE_EN is defined.
interface entity_renderer_if;
    logic        draw_start;
    logic [29:0] entity;
    logic [2:0]  entity_state;
`ifdef ENTITY_RENDERER_ERASE_EN
    logic        erase;
`endif
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour_out;
    logic        plot;
    logic        busy;
    logic        draw_done;

    // Source side: issues render requests, observes pixels.
    modport master (
`ifdef ENTITY_RENDERER_ERASE_EN
        output erase,
`endif
        output draw_start, entity, entity_state,
        input  x_out, y_out, colour_out, plot, busy, draw_done
    );

    // Renderer side.
    modport slave (
`ifdef ENTITY_RENDERER_ERASE_EN
        input  erase,
`endif
        input  draw_start, entity, entity_state,
        output x_out, y_out, colour_out, plot, busy, draw_done
    );
endinterface

// File: rtl/entity_renderer.sv
// Entity renderer: rasterises a latched square entity (ship/asteroid/shot) into
// one pixel per cycle, clipping at the screen edge.
// Optional feature macro: ENTITY_RENDERER_ERASE_EN (adds erase input forcing colour 0).
module entity_renderer #(
    parameter int unsigned SCREEN_W      = 160,
    parameter int unsigned SCREEN_H      = 120,
    parameter int unsigned SHIP_SIZE     = 4,
    parameter int unsigned ASTEROID_SIZE = 8,
    parameter int unsigned SHOT_SIZE     = 1
) (
    input  logic               clk,
    input  logic               reset_n,  // active-high despite the name
    entity_renderer_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  dx_q, dx_d, dy_q, dy_d;
    logic [7:0]  ent_x_q, ent_x_d;
    logic [6:0]  ent_y_q, ent_y_d;
    logic [2:0]  ent_col_q, ent_col_d;
    logic [2:0]  ent_type_q, ent_type_d;
    logic        erase_q, erase_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  col_q, col_d;
    logic        plot_q, plot_d;
    logic        done_q, done_d;

    // Pixel source selection: on acceptance the first pixel comes straight from the bus.
    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic [2:0]  base_col;
    logic [7:0]  len;
    logic        emit;
    logic [8:0]  sx;
    logic [7:0]  sy;
    logic        erase_in;

    logic unused_bits;
    assign unused_bits = ^bus.entity[10:0];

`ifdef ENTITY_RENDERER_ERASE_EN
    assign erase_in = bus.erase;
`else
    assign erase_in = 1'b0;
`endif

    function automatic logic [7:0] edge_len(input logic [2:0] t);
        case (t)
            3'b100:  edge_len = 8'(SHIP_SIZE);
            3'b010:  edge_len = 8'(ASTEROID_SIZE);
            3'b001:  edge_len = 8'(SHOT_SIZE);
            default: edge_len = 8'd0;
        endcase
    endfunction

    // Next-state, offset stepping and pixel output generation.
    always_comb begin
        state_d    = state_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        ent_x_d    = ent_x_q;
        ent_y_d    = ent_y_q;
        ent_col_d  = ent_col_q;
        ent_type_d = ent_type_q;
        erase_d    = erase_q;
        x_d        = x_q;
        y_d        = y_q;
        col_d      = col_q;
        plot_d     = 1'b0;
        done_d     = 1'b0;
        emit       = 1'b0;

        if (state_q == S_IDLE) begin
            base_x   = bus.entity[29:22];
            base_y   = bus.entity[21:15];
            base_col = erase_in ? 3'b000 : bus.entity[14:12];
            len      = edge_len(bus.entity_state);
        end else begin
            base_x   = ent_x_q;
            base_y   = ent_y_q;
            base_col = erase_q ? 3'b000 : ent_col_q;
            len      = edge_len(ent_type_q);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.draw_start) begin
                    ent_x_d    = bus.entity[29:22];
                    ent_y_d    = bus.entity[21:15];
                    ent_col_d  = bus.entity[14:12];
                    ent_type_d = bus.entity_state;
                    erase_d    = erase_in;
                    // Zero length means the type was not one-hot.
                    if (bus.entity[11] && (len != 8'd0)) begin
                        state_d = S_DRAW;
                        dx_d    = 8'd0;
                        dy_d    = 8'd0;
                        emit    = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DRAW: begin
                if ((dx_q == len - 8'd1) && (dy_q == len - 8'd1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    dx_d    = 8'd0;
                    dy_d    = 8'd0;
                end else begin
                    if (dx_q == len - 8'd1) begin
                        dx_d = 8'd0;
                        dy_d = dy_q + 8'd1;
                    end else begin
                        dx_d = dx_q + 8'd1;
                    end
                    emit = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // One bit wider than the field so off-screen sums clip instead of wrapping.
        sx = {1'b0, base_x} + {1'b0, dx_d};
        sy = {1'b0, base_y} + dy_d;
        if (emit && (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H))) begin
            plot_d = 1'b1;
            x_d    = sx[7:0];
            y_d    = sy[6:0];
            col_d  = base_col;
        end
    end

    // State, latched entity and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q    <= S_IDLE;
            dx_q       <= 8'd0;
            dy_q       <= 8'd0;
            ent_x_q    <= 8'd0;
            ent_y_q    <= 7'd0;
            ent_col_q  <= 3'd0;
            ent_type_q <= 3'd0;
            erase_q    <= 1'b0;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            col_q      <= 3'd0;
            plot_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            ent_x_q    <= ent_x_d;
            ent_y_q    <= ent_y_d;
            ent_col_q  <= ent_col_d;
            ent_type_q <= ent_type_d;
            erase_q    <= erase_d;
            x_q        <= x_d;
            y_q        <= y_d;
            col_q      <= col_d;
            plot_q     <= plot_d;
            done_q     <= done_d;
        end
    end

    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.colour_out = col_q;
    assign bus.plot       = plot_q;
    assign bus.draw_done  = done_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_entity_renderer.sv
// Scoreboard bench for entity_renderer: the driver pushes every expected pixel
// and draw_done (with the cycle it must appear on); a negedge monitor pops and compares.
module tb_entity_renderer;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    entity_renderer_if bus();

    entity_renderer #(
        .SCREEN_W      (160),
        .SCREEN_H      (120),
        .SHIP_SIZE     (4),
        .ASTEROID_SIZE (8),
        .SHOT_SIZE     (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit done;
        int x;
        int y;
        int col;
        int stamp;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    int   win_lo = 1;
    int   win_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] t);
        case (t)
            3'b100:  return 4;
            3'b010:  return 8;
            3'b001:  return 1;
            default: return 0;
        endcase
    endfunction

    // Drive one request, record the expected pixel stream, return after acceptance.
    task automatic start_entity(input int x, input int y, input int col, input bit act,
                                input logic [2:0] t, input bit er, output int sc);
        int   n;
        exp_t e;
        @(posedge clk); #1;
        sc = cyc;
        bus.entity       = {8'(x), 7'(y), 3'(col), act, 11'($urandom)};
        bus.entity_state = t;
`ifdef ENTITY_RENDERER_ERASE_EN
        bus.erase = er;
`endif
        bus.draw_start = 1'b1;
        n = act ? size_of(t) : 0;
        for (int dy = 0; dy < n; dy++) begin
            for (int dx = 0; dx < n; dx++) begin
                if (x + dx < 160 && y + dy < 120) begin
                    e.done  = 1'b0;
                    e.x     = x + dx;
                    e.y     = y + dy;
                    e.col   = er ? 0 : col;
                    e.stamp = sc + 1 + dy * n + dx;
                    sb.push_back(e);
                end
            end
        end
        e.done  = 1'b1;
        e.x     = 0;
        e.y     = 0;
        e.col   = 0;
        e.stamp = sc + 1 + n * n;
        sb.push_back(e);
        win_lo = sc + 1;
        win_hi = sc + 1 + n * n;
        @(posedge clk); #1;
        // Scramble inputs to confirm the renderer works from its latched copy.
        bus.draw_start   = 1'b0;
        bus.entity       = 30'($urandom);
        bus.entity_state = 3'($urandom);
`ifdef ENTITY_RENDERER_ERASE_EN
        bus.erase = 1'($urandom);
`endif
    endtask

    task automatic wait_idle();
        while (cyc <= win_hi) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: compare DUT outputs against the head of the scoreboard each cycle.
    always @(negedge clk) begin
        bit   exp_plot;
        bit   exp_done;
        exp_t e;
        chk("busy", int'(bus.busy), int'(cyc >= win_lo && cyc <= win_hi));
        exp_plot = (sb.size() > 0) && !sb[0].done && (sb[0].stamp == cyc);
        chk("plot", int'(bus.plot), int'(exp_plot));
        if (exp_plot) begin
            e = sb.pop_front();
            if (bus.plot) begin
                chk("x_out", int'(bus.x_out), e.x);
                chk("y_out", int'(bus.y_out), e.y);
                chk("colour_out", int'(bus.colour_out), e.col);
            end
        end
        exp_done = (sb.size() > 0) && sb[0].done && (sb[0].stamp == cyc);
        chk("draw_done", int'(bus.draw_done), int'(exp_done));
        if (exp_done) void'(sb.pop_front());
        while (sb.size() > 0 && sb[0].stamp < cyc) begin
            e = sb.pop_front();
            chk("stale_event", e.stamp, cyc);
        end
    end

    initial begin
        int   sc;
        int   x, y, col;
        bit   act;
        logic [2:0] t;
        exp_t keep[$];

        bus.draw_start   = 1'b0;
        bus.entity       = '0;
        bus.entity_state = '0;
`ifdef ENTITY_RENDERER_ERASE_EN
        bus.erase = 1'b0;
`endif
        // Start asserted with reset: must be ignored.
        @(posedge clk); #1;
        bus.draw_start   = 1'b1;
        bus.entity       = {8'd5, 7'd5, 3'd7, 1'b1, 11'd0};
        bus.entity_state = 3'b100;
        @(posedge clk); #1;
        bus.draw_start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        chk("reset_x_out", int'(bus.x_out), 0);
        chk("reset_y_out", int'(bus.y_out), 0);
        chk("reset_colour_out", int'(bus.colour_out), 0);
        repeat (3) @(posedge clk);
        #1;

        // Ship fully on screen.
        start_entity(10, 20, 6, 1'b1, 3'b100, 1'b0, sc);
        wait_idle();
        // Asteroid clipped at the bottom-right corner.
        start_entity(156, 118, 5, 1'b1, 3'b010, 1'b0, sc);
        wait_idle();
        // Inactive shot, then invalid type.
        start_entity(30, 30, 3, 1'b0, 3'b001, 1'b0, sc);
        wait_idle();
        start_entity(30, 30, 3, 1'b1, 3'b000, 1'b0, sc);
        wait_idle();
        start_entity(159, 119, 2, 1'b1, 3'b001, 1'b0, sc);
        wait_idle();

        // Second start during an asteroid render is ignored.
        start_entity(40, 40, 4, 1'b1, 3'b010, 1'b0, sc);
        repeat (10) @(posedge clk);
        #1;
        bus.draw_start   = 1'b1;
        bus.entity       = {8'd1, 7'd1, 3'd1, 1'b1, 11'd0};
        bus.entity_state = 3'b100;
        @(posedge clk); #1;
        bus.draw_start = 1'b0;
        wait_idle();

        // Reset mid-render: effective from cycle 30, no draw_done afterwards.
        start_entity(50, 30, 7, 1'b1, 3'b010, 1'b0, sc);
        while (cyc < sc + 29) begin
            @(posedge clk); #1;
        end
        reset_n          = 1'b1;
        bus.draw_start   = 1'b1;
        bus.entity       = {8'd2, 7'd2, 3'd2, 1'b1, 11'd0};
        bus.entity_state = 3'b100;
        keep = {};
        foreach (sb[i]) if (sb[i].stamp < sc + 30) keep.push_back(sb[i]);
        sb     = keep;
        win_hi = sc + 29;
        @(posedge clk); #1;
        bus.draw_start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        chk("abort_x_out", int'(bus.x_out), 0);
        chk("abort_y_out", int'(bus.y_out), 0);
        chk("abort_colour_out", int'(bus.colour_out), 0);
        repeat (5) @(posedge clk);
        #1;

`ifdef ENTITY_RENDERER_ERASE_EN
        start_entity(10, 20, 7, 1'b1, 3'b100, 1'b1, sc);
        wait_idle();
`endif

        // Randomized entities, biased towards the screen edges.
        for (int k = 0; k < 40; k++) begin
            x   = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 159) : $urandom_range(0, 159);
            y   = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 119) : $urandom_range(0, 119);
            col = $urandom_range(0, 7);
            act = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 4))
                0:       t = 3'b100;
                1:       t = 3'b010;
                2:       t = 3'b001;
                3:       t = 3'b010;
                default: t = 3'($urandom);
            endcase
`ifdef ENTITY_RENDERER_ERASE_EN
            start_entity(x, y, col, act, t, 1'($urandom), sc);
`else
            start_entity(x, y, col, act, t, 1'b0, sc);
`endif
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
